aes_encryptor: RTL and testbench
================================

# aes_encryptor

Iterative AES-128 encryption core: the forward counterpart of the team's AES decryptor, sharing its port style and external round-key handshake. Accepts one 128-bit plaintext block, performs the initial AddRoundKey plus 10 rounds (one round per clock), and returns the ciphertext with a one-cycle ready pulse. Round keys come from the existing external key store, indexed by `SelKey`. The encryptor holds no key schedule.

## Interface
- No parameters. AES-128 only: Nr = 10.
- Clk  in  1  system clock; all state updates on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- En  in  1  start request; sampled only in IDLE.
- Key  in  128  round key for index `SelKey`, valid combinationally in the same cycle (asynchronous-read key store).
- PT  in  128  plaintext; captured in the cycle `En` is accepted.
- SelKey  out  4  registered round-key index, 0..10.
- Ry  out  1  registered one-cycle pulse: `CT` is valid.
- CT  out  128  registered ciphertext; holds until the next completion.

## Operation
- Byte order follows FIPS-197. Bits [127:120] are byte 0. Byte i sits at row i%4, column i/4 (column-major).
- Datapath: one 128-bit state register. Combinational per-cycle round logic:
  - SubBytes: 16 instances of the forward S-box leaf `aes_sbox`, 8-bit in/out, FIPS-197 table.
  - ShiftRows: row r rotated left by r bytes.
  - MixColumns: GF(2^8) with xtime(b) = {b[6:0],0} ^ (b[7] ? 8'h1b : 0). Each output byte is 2·a0 ^ 3·a1 ^ a2 ^ a3, rotated per row.
  - AddRoundKey: XOR with `Key`.
- FSM states: IDLE, INIT, ROUND, FINAL.
- IDLE, `En`=1: state reg <= `PT`, `SelKey` <= 0, next state INIT.
- IDLE, `En`=0: hold.
- INIT: state <= state ^ `Key`, `SelKey` <= 1, next state ROUND.
- ROUND: state <= MixColumns(ShiftRows(SubBytes(state))) ^ `Key`. `SelKey` increments.
  - When the current `SelKey` is 9: `SelKey` <= 10, next state FINAL.
- FINAL: `CT` <= ShiftRows(SubBytes(state)) ^ `Key` (no MixColumns). State reg takes the same value. `Ry` <= 1, `SelKey` <= 0, next state IDLE.
- `Ry` is cleared on every cycle it is not set by FINAL.
- `En` is ignored outside IDLE. A pending `En` is not queued.
- `PT` is sampled only at acceptance; later changes to `PT` have no effect.
- `Key` must be stable for the whole cycle in which a given `SelKey` is presented.

## Timing
- Reset values, applied immediately and asynchronously while `Rst`=0: FSM = IDLE, state reg = 0, `SelKey` = 0, `Ry` = 0, `CT` = 0.
- `En` accepted at edge T (FSM in IDLE).
- `SelKey` sequence:
  - Cycle T+1: 0 (INIT).
  - Cycles T+2..T+10: 1..9 (ROUND).
  - Cycle T+11: 10 (FINAL).
  - Cycle T+12: 0.
- `Ry`=1 and the new `CT` are visible in cycle T+12. Latency from `En` to `Ry` is 12 cycles.
- Back-to-back: in cycle T+12 the FSM is already IDLE. `En`=1 in that cycle is accepted, giving a 12-cycle issue interval.
- Reset mid-operation (`Rst` low in any state): abort, no `Ry`, `CT` cleared to 0. After `Rst` deasserts, the next `En` starts cleanly from INIT.
- `Rst` low in the same cycle as `En`: reset wins, request dropped.
- `Rst` low during a `Ry` cycle: `Ry` drops immediately.

## Test plan
- Bench supplies a key-expansion model driving `Key` from `SelKey`.
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, PT 00112233445566778899aabbccddeeff -> `CT` 69c4e0d86a7b0430d8cdb78070b4c55a, `Ry` pulse exactly at T+12, `SelKey` trace 0,1..10,0.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, PT 3243f6a8885a308d313198a2e0370734 -> `CT` 3925841d02dc09fbdc118597196a0b32.
- All-zero key and PT -> `CT` 66e94bd4ef8a2c3b884cfa59ca342b2e.
- Back-to-back run:
  - Issue C.1, then App. B with `En` in the `Ry` cycle -> both correct, `Ry` pulses 12 cycles apart.
  - `En` held high throughout -> exactly one start per 12 cycles.
  - `PT` changed mid-run -> result unaffected.
- Async reset: assert `Rst`=0 at T+5 of a C.1 run -> `Ry`=0, `CT`=0, `SelKey`=0 immediately. Release, restart C.1 -> correct `CT` 12 cycles after `En`.
- Reset check: after power-up reset, with `En`=0 for 50 cycles -> `Ry` stays 0, `SelKey` stays 0, `CT` stays 0.

Source files
------------

// File: rtl/aes_encryptor.sv
// ============================================================================
// Module   : aes_encryptor (with leaf aes_sbox)
// Brief    : Iterative AES-128 encryption core. One round per clock. Round
//            keys are read from an external asynchronous key store that is
//            indexed by SelKey.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// ----------------------------------------------------------------------------
// aes_sbox : forward AES S-box, combinational table lookup
// ----------------------------------------------------------------------------
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Entry 0 occupies the most significant byte of the table.
  localparam logic [2047:0] c_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Bit offset of entry din is (255 - din) * 8, i.e. {~din, 3'b000}.
  logic [10:0] w_idx;
  assign w_idx = {~din, 3'b000};
  assign dout  = c_TABLE[w_idx +: 8];

endmodule

// ----------------------------------------------------------------------------
// aes_encryptor : top level
// ----------------------------------------------------------------------------
module aes_encryptor (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         En,
  input  logic [127:0] Key,
  input  logic [127:0] PT,
  output logic [3:0]   SelKey,
  output logic         Ry,
  output logic [127:0] CT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    ROUND = 2'd2,
    FINAL = 2'd3
  } state_t;

  localparam logic [3:0] c_LAST_MID_KEY = 4'd9;

  state_t       r_fsm;
  state_t       w_fsm_nxt;
  logic [127:0] r_state;
  logic [127:0] w_sub;
  logic [127:0] w_shift;
  logic [127:0] w_mix;
  logic [127:0] w_round;
  logic [127:0] w_final;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte i lives at bits [127-8i -: 8]; row = i%4, column = i/4.
  for (genvar i = 0; i < 16; i++) begin : g_sub
    aes_sbox u_sbox (
      .din  (r_state[127-8*i -: 8]),
      .dout (w_sub[127-8*i -: 8])
    );
  end

  // Row r rotates left by r: output column c takes input column (c+r)%4.
  for (genvar c = 0; c < 4; c++) begin : g_shift_col
    for (genvar r = 0; r < 4; r++) begin : g_shift_row
      assign w_shift[127-8*(4*c+r) -: 8] = w_sub[127-8*(4*((c+r)%4)+r) -: 8];
    end
  end

  // out_r = 2*a_r ^ 3*a_(r+1) ^ a_(r+2) ^ a_(r+3), indices mod 4 within a column.
  for (genvar c = 0; c < 4; c++) begin : g_mix_col
    for (genvar r = 0; r < 4; r++) begin : g_mix_row
      assign w_mix[127-8*(4*c+r) -: 8] =
          xtime(w_shift[127-8*(4*c+r) -: 8])
        ^ xtime(w_shift[127-8*(4*c+((r+1)%4)) -: 8])
        ^ w_shift[127-8*(4*c+((r+1)%4)) -: 8]
        ^ w_shift[127-8*(4*c+((r+2)%4)) -: 8]
        ^ w_shift[127-8*(4*c+((r+3)%4)) -: 8];
    end
  end

  assign w_round = w_mix ^ Key;
  assign w_final = w_shift ^ Key;

  // FSM state register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_fsm <= IDLE;
    else      r_fsm <= w_fsm_nxt;
  end

  // Next-state logic; the last middle round is recognised from SelKey.
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      IDLE:    if (En) w_fsm_nxt = INIT;
      INIT:    w_fsm_nxt = ROUND;
      ROUND:   if (SelKey == c_LAST_MID_KEY) w_fsm_nxt = FINAL;
      FINAL:   w_fsm_nxt = IDLE;
      default: w_fsm_nxt = IDLE;
    endcase
  end

  // Datapath, key index and result registers; Ry is a single-cycle pulse.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= '0;
      SelKey  <= '0;
      Ry      <= 1'b0;
      CT      <= '0;
    end else begin
      Ry <= 1'b0;
      case (r_fsm)
        IDLE: begin
          if (En) begin
            r_state <= PT;
            SelKey  <= 4'd0;
          end
        end
        INIT: begin
          r_state <= r_state ^ Key;
          SelKey  <= 4'd1;
        end
        ROUND: begin
          r_state <= w_round;
          SelKey  <= SelKey + 4'd1;
        end
        FINAL: begin
          r_state <= w_final;
          CT      <= w_final;
          Ry      <= 1'b1;
          SelKey  <= 4'd0;
        end
        default: begin
          SelKey <= 4'd0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_aes_encryptor.sv
// ============================================================================
// Module   : tb_aes_encryptor
// Brief    : Directed self-checking bench for aes_encryptor with a
//            key-expansion model acting as the external key store.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_encryptor;

  localparam logic [2047:0] c_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [127:0] c_C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] c_C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] c_C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] c_B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] c_B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] c_B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] c_Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         En;
  logic [127:0] Key;
  logic [127:0] PT;
  logic [3:0]   SelKey;
  logic         Ry;
  logic [127:0] CT;

  logic [127:0] rk [0:10];
  int n_tests = 0;
  int n_fail  = 0;

  aes_encryptor dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .En     (En),
    .Key    (Key),
    .PT     (PT),
    .SelKey (SelKey),
    .Ry     (Ry),
    .CT     (CT)
  );

  always #5 Clk = ~Clk;

  // Asynchronous-read key store.
  always_comb begin
    Key = '0;
    if (SelKey <= 4'd10) Key = rk[SelKey];
  end

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [2047:0] t;
    logic [10:0]   idx;
    t   = c_SBOX;
    idx = {~x, 3'b000};
    return t[idx +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // FIPS-197 AES-128 key expansion into the key store.
  task automatic load_key(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        t = t ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge: present a request for the next rising edge.
  task automatic issue(input logic [127:0] k, input logic [127:0] p);
    load_key(k);
    PT = p;
    En = 1'b1;
  endtask

  // Follow one block from the accepting edge to the Ry cycle (cycle T+12).
  task automatic watch(input logic [127:0] exp_ct, input string tag,
                       input bit hold_en, input bit pt_change);
    logic [3:0] exp_sel;
    @(posedge Clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge Clk);
      if (k == 1 && !hold_en) En = 1'b0;
      if (k == 3 && pt_change) PT = ~PT;
      exp_sel = (k == 1 || k == 12) ? 4'd0 : 4'(k - 1);
      check($sformatf("%s_sel_c%0d", tag, k), {124'h0, SelKey}, {124'h0, exp_sel});
      check($sformatf("%s_ry_c%0d", tag, k), {127'h0, Ry}, {127'h0, (k == 12)});
      if (k == 12) check($sformatf("%s_ct", tag), CT, exp_ct);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b0;
    En  = 1'b0;
    PT  = '0;
    load_key('0);
    repeat (3) @(negedge Clk);
    check("rst_ry", {127'h0, Ry}, 128'h0);
    check("rst_sel", {124'h0, SelKey}, 128'h0);
    check("rst_ct", CT, 128'h0);
    Rst = 1'b1;

    // Idle after reset: nothing moves.
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      check($sformatf("idle_ry_%0d", i), {127'h0, Ry}, 128'h0);
      check($sformatf("idle_sel_%0d", i), {124'h0, SelKey}, 128'h0);
      check($sformatf("idle_ct_%0d", i), CT, 128'h0);
    end

    // Reference vectors.
    issue(c_C1_KEY, c_C1_PT);
    watch(c_C1_CT, "c1", 1'b0, 1'b0);
    @(negedge Clk);
    issue(c_B_KEY, c_B_PT);
    watch(c_B_CT, "appb", 1'b0, 1'b0);
    @(negedge Clk);
    issue('0, '0);
    watch(c_Z_CT, "zero", 1'b0, 1'b0);

    // Back-to-back: second request presented in the Ry cycle.
    @(negedge Clk);
    issue(c_C1_KEY, c_C1_PT);
    watch(c_C1_CT, "b2b_c1", 1'b0, 1'b0);
    issue(c_B_KEY, c_B_PT);
    watch(c_B_CT, "b2b_b", 1'b0, 1'b0);

    // En held high: exactly one start per 12 cycles.
    @(negedge Clk);
    issue('0, '0);
    watch(c_Z_CT, "hold1", 1'b1, 1'b0);
    watch(c_Z_CT, "hold2", 1'b1, 1'b0);
    En = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check($sformatf("hold_after_ry_%0d", i), {127'h0, Ry}, 128'h0);
      check($sformatf("hold_after_sel_%0d", i), {124'h0, SelKey}, 128'h0);
    end

    // Plaintext changed mid-run.
    issue(c_C1_KEY, c_C1_PT);
    watch(c_C1_CT, "ptchg", 1'b0, 1'b1);

    // Asynchronous reset at cycle T+5 of a run.
    @(negedge Clk);
    issue(c_C1_KEY, c_C1_PT);
    @(posedge Clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge Clk);
      if (k == 1) En = 1'b0;
    end
    Rst = 1'b0;
    #1;
    check("abort_ry", {127'h0, Ry}, 128'h0);
    check("abort_sel", {124'h0, SelKey}, 128'h0);
    check("abort_ct", CT, 128'h0);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    issue(c_C1_KEY, c_C1_PT);
    watch(c_C1_CT, "restart", 1'b0, 1'b0);

    // Reset during the Ry cycle drops Ry at once.
    Rst = 1'b0;
    #1;
    check("ry_drop", {127'h0, Ry}, 128'h0);
    check("ry_drop_ct", CT, 128'h0);
    @(negedge Clk);

    // Reset and En together: the request is dropped.
    En = 1'b1;
    PT = c_C1_PT;
    @(posedge Clk);
    @(negedge Clk);
    En  = 1'b0;
    Rst = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge Clk);
      check($sformatf("drop_ry_%0d", i), {127'h0, Ry}, 128'h0);
      check($sformatf("drop_sel_%0d", i), {124'h0, SelKey}, 128'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
